// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with exception, interrupt and mret sequencing that redirects fetch.
// Optional: define CSR_VECTORED_EN for vectored interrupt dispatch (mtvec mode 01).
module csr_trap_unit #(
    parameter int              XLEN        = 32,
    parameter int              COUNTER_W   = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_valid,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            exc_valid,
    input  logic [XLEN-2:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            retire,
    input  logic            irq_msi,
    input  logic            irq_mti,
    input  logic            irq_mei,
    input  logic [XLEN-1:0] int_pc,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            irq_pending
);

    localparam bit              HAS_HI   = (COUNTER_W == 64);
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h0000_0888);

    // Only modes 00 and 01 survive; the plain build keeps the low bits at zero.
    function automatic logic [XLEN-1:0] legal_mtvec(input logic [XLEN-1:0] v);
`ifdef CSR_VECTORED_EN
        return {v[XLEN-1:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
        return v & ~XLEN'(3);
`endif
    endfunction

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] cyc_lo_q, cyc_lo_d, cyc_hi_q, cyc_hi_d;
    logic [XLEN-1:0] ins_lo_q, ins_lo_d, ins_hi_q, ins_hi_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [XLEN-1:0] mip_w, pend_w, mstatus_rd, wval, trap_base, irq_target;
    logic [XLEN:0]   cyc_inc, ins_inc;
    logic [4:0]      irq_code;
    logic            irq_any, mapped, csr_we;
    logic            take_exc, take_irq, take_mret, do_wr;

    always_comb begin
        mip_w     = '0;
        mip_w[3]  = irq_msi;
        mip_w[7]  = irq_mti;
        mip_w[11] = irq_mei;
    end

    assign pend_w  = mie_q & mip_w & {XLEN{mstatus_mie_q}};
    assign irq_any = |pend_w;

    always_comb begin
        if (pend_w[11])     irq_code = 5'd11;
        else if (pend_w[3]) irq_code = 5'd3;
        else                irq_code = 5'd7;
    end

    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_EN
    assign irq_target = (mtvec_q[1:0] == 2'b01) ? trap_base + (XLEN'(irq_code) << 2) : trap_base;
`else
    assign irq_target = trap_base;
`endif

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[3]     = mstatus_mie_q;
    end

    always_comb begin
        csr_rdata = '0;
        mapped    = 1'b1;
        case (csr_addr)
            12'h300:          csr_rdata = mstatus_rd;
            12'h304:          csr_rdata = mie_q;
            12'h305:          csr_rdata = mtvec_q;
            12'h340:          csr_rdata = mscratch_q;
            12'h341:          csr_rdata = mepc_q;
            12'h342:          csr_rdata = mcause_q;
            12'h343:          csr_rdata = mtval_q;
            12'h344:          csr_rdata = mip_w;
            12'hB00, 12'hC00: csr_rdata = cyc_lo_q;
            12'hB80, 12'hC80: csr_rdata = cyc_hi_q;
            12'hB02, 12'hC02: csr_rdata = ins_lo_q;
            12'hB82, 12'hC82: csr_rdata = ins_hi_q;
            12'hF14:          csr_rdata = '0;
            default:          mapped    = 1'b0;
        endcase
    end

    assign csr_illegal = csr_valid && (!mapped || (csr_addr[11:10] == 2'b11 && csr_op != 2'b00));
    assign csr_we      = csr_valid && !csr_illegal && (csr_op != 2'b00);

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    // A trap or mret in the same cycle swallows any CSR write.
    assign take_exc  = exc_valid;
    assign take_irq  = !exc_valid && irq_any;
    assign take_mret = !exc_valid && !irq_any && mret;
    assign do_wr     = csr_we && !take_exc && !take_irq && !take_mret;

    assign cyc_inc = {1'b0, cyc_lo_q} + (XLEN+1)'(1);
    assign ins_inc = {1'b0, ins_lo_q} + (XLEN+1)'(retire);

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        cyc_lo_d       = cyc_inc[XLEN-1:0];
        cyc_hi_d       = HAS_HI ? cyc_hi_q + XLEN'(cyc_inc[XLEN]) : '0;
        ins_lo_d       = ins_inc[XLEN-1:0];
        ins_hi_d       = HAS_HI ? ins_hi_q + XLEN'(ins_inc[XLEN]) : '0;
        redirect_d     = 1'b0;
        redirect_pc_d  = redirect_pc_q;

        if (take_exc) begin
            mepc_d         = exc_pc & ~XLEN'(3);
            mcause_d       = {1'b0, exc_cause};
            mtval_d        = exc_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            redirect_d     = 1'b1;
            redirect_pc_d  = trap_base;
        end else if (take_irq) begin
            mepc_d         = int_pc & ~XLEN'(3);
            mcause_d       = {1'b1, (XLEN-1)'(irq_code)};
            mtval_d        = '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            redirect_d     = 1'b1;
            redirect_pc_d  = irq_target;
        end else if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            redirect_d     = 1'b1;
            redirect_pc_d  = mepc_q;
        end else if (do_wr) begin
            case (csr_addr)
                12'h300: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                12'h304: mie_d      = wval & MIE_MASK;
                12'h305: mtvec_d    = legal_mtvec(wval);
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = wval & ~XLEN'(3);
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                // A written half takes the value as-is; the other half keeps counting.
                12'hB00: begin
                    cyc_lo_d = wval;
                    cyc_hi_d = cyc_hi_q;
                end
                12'hB80: if (HAS_HI) cyc_hi_d = wval;
                12'hB02: begin
                    ins_lo_d = wval;
                    ins_hi_d = ins_hi_q;
                end
                12'hB82: if (HAS_HI) ins_hi_d = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= legal_mtvec(MTVEC_RESET);
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            cyc_lo_q       <= '0;
            cyc_hi_q       <= '0;
            ins_lo_q       <= '0;
            ins_hi_q       <= '0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            cyc_lo_q       <= cyc_lo_d;
            cyc_hi_q       <= cyc_hi_d;
            ins_lo_q       <= ins_lo_d;
            ins_hi_q       <= ins_hi_d;
            redirect_q     <= redirect_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign irq_pending = irq_any;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: stimulus queues expected CSR reads and redirects,
// a negedge monitor pops and compares whenever the DUT presents a response.
module tb_csr_trap_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
`ifdef CSR_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        exc_valid = 1'b0;
    logic [30:0] exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        mret = 1'b0;
    logic        retire = 1'b0;
    logic        irq_msi = 1'b0;
    logic        irq_mti = 1'b0;
    logic        irq_mei = 1'b0;
    logic [31:0] int_pc = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        irq_pending;

    csr_trap_unit #(
        .XLEN(32), .COUNTER_W(64), .MTVEC_RESET(MTVEC_RST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret(mret), .retire(retire),
        .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei), .int_pc(int_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rd;
        bit          chk_rd;
        logic        ill;
        logic        pend;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] rdr_q[$];
    int          checks = 0;
    int          failures = 0;
    rd_exp_t     mon_e;
    logic [31:0] mon_pc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_valid) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL csr_unexpected addr=%h got_rdata=%h", csr_addr, csr_rdata);
                end else begin
                    mon_e = rd_q.pop_front();
                    checks++;
                    if (csr_illegal !== mon_e.ill) begin
                        failures++;
                        $display("FAIL illegal addr=%h got=%b exp=%b", mon_e.addr, csr_illegal, mon_e.ill);
                    end
                    checks++;
                    if (irq_pending !== mon_e.pend) begin
                        failures++;
                        $display("FAIL irq_pending addr=%h got=%b exp=%b", mon_e.addr, irq_pending, mon_e.pend);
                    end
                    if (mon_e.chk_rd) begin
                        checks++;
                        if (csr_rdata !== mon_e.rd) begin
                            failures++;
                            $display("FAIL rdata addr=%h got=%h exp=%h", mon_e.addr, csr_rdata, mon_e.rd);
                        end
                    end
                    $display("csr addr=%h rdata=%h illegal=%b pending=%b", mon_e.addr, csr_rdata, csr_illegal, irq_pending);
                end
            end
            if (redirect) begin
                checks++;
                if (rdr_q.size() == 0) begin
                    failures++;
                    $display("FAIL redirect_unexpected got_pc=%h", redirect_pc);
                end else begin
                    mon_pc = rdr_q.pop_front();
                    if (redirect_pc !== mon_pc) begin
                        failures++;
                        $display("FAIL redirect_pc got=%h exp=%h", redirect_pc, mon_pc);
                    end
                    $display("redirect pc=%h", redirect_pc);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input logic [31:0] erd, input bit chk, input logic eill, input logic epend);
        rd_exp_t t;
        csr_valid = v; csr_addr = a; csr_op = op; csr_wdata = wd;
        if (v) begin
            t.addr = a; t.rd = erd; t.chk_rd = chk; t.ill = eill; t.pend = epend;
            rd_q.push_back(t);
        end
        @(posedge clk); #1;
        csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0;
        exc_valid = 1'b0; mret = 1'b0; retire = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] erd);
        cyc(1'b1, a, 2'b00, 32'h0, erd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd, input logic [31:0] erd);
        cyc(1'b1, a, op, wd, erd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 12'h000, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_redirect", redirect, 1'b0);
        check_word("reset_redirect_pc", redirect_pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        rd(12'h300, 32'h0000_1800);
        rd(12'h305, MTVEC_RST);

        wr(12'h340, 2'b01, 32'hDEAD_BEEF, 32'h0);
        wr(12'h340, 2'b10, 32'h0000_FFFF, 32'hDEAD_BEEF);
        wr(12'h340, 2'b11, 32'hFF00_0000, 32'hDEAD_FFFF);
        rd(12'h340, 32'h00AD_FFFF);
        wr(12'h305, 2'b01, 32'h0000_0200, MTVEC_RST);

        // exception with a concurrent mscratch write that must be dropped
        exc_valid = 1'b1; exc_cause = 31'd2; exc_pc = 32'h100; exc_tval = 32'h13;
        rdr_q.push_back(32'h200);
        wr(12'h340, 2'b01, 32'h1234_5678, 32'h00AD_FFFF);
        rd(12'h341, 32'h100);
        rd(12'h342, 32'h2);
        rd(12'h343, 32'h13);
        rd(12'h300, 32'h0000_1800);
        rd(12'h340, 32'h00AD_FFFF);

        // interrupt: MEI beats MTI
        wr(12'h304, 2'b01, 32'hFFFF_FFFF, 32'h0);
        rd(12'h304, 32'h888);
        wr(12'h305, 2'b01, 32'h201, 32'h200);
        rd(12'h305, VEC ? 32'h201 : 32'h200);
        irq_mti = 1'b1; irq_mei = 1'b1; int_pc = 32'h444;
        rd(12'h344, 32'h880);
        wr(12'h300, 2'b01, 32'h8, 32'h0000_1800);
        rdr_q.push_back(VEC ? 32'h22C : 32'h200);
        cyc(1'b1, 12'h300, 2'b00, 32'h0, 32'h0000_1808, 1'b1, 1'b0, 1'b1);
        irq_mti = 1'b0; irq_mei = 1'b0;
        rd(12'h342, 32'h8000_000B);
        rd(12'h341, 32'h444);
        rd(12'h343, 32'h0);
        rd(12'h300, 32'h0000_1880);

        // mret returns to mepc and restores MIE
        mret = 1'b1;
        rdr_q.push_back(32'h444);
        rd(12'h300, 32'h0000_1880);
        rd(12'h300, 32'h0000_1888);

        // interrupt wins over a concurrent mret
        mret = 1'b1; irq_msi = 1'b1; int_pc = 32'h555;
        rdr_q.push_back(VEC ? 32'h20C : 32'h200);
        cyc(1'b1, 12'h304, 2'b00, 32'h0, 32'h888, 1'b1, 1'b0, 1'b1);
        irq_msi = 1'b0;
        rd(12'h342, 32'h8000_0003);
        rd(12'h341, 32'h554);
        rd(12'h300, 32'h0000_1880);

        // back-to-back exceptions give consecutive pulses
        exc_valid = 1'b1; exc_cause = 31'd5; exc_pc = 32'h600; exc_tval = 32'h0;
        rdr_q.push_back(32'h200);
        idle();
        exc_valid = 1'b1; exc_cause = 31'd7; exc_pc = 32'h700;
        rdr_q.push_back(32'h200);
        idle();
        rd(12'h341, 32'h700);
        rd(12'h342, 32'h7);

        // illegal accesses
        cyc(1'b1, 12'hC00, 2'b01, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'hC02, 2'b01, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0);
        rd(12'hB02, 32'h0);
        cyc(1'b1, 12'h7C0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        rd(12'hF14, 32'h0);
        cyc(1'b1, 12'hF14, 2'b10, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);

        // minstret counting and write-over-increment
        for (int i = 0; i < 3; i++) begin
            retire = 1'b1;
            idle();
        end
        rd(12'hB02, 32'h3);
        rd(12'hC02, 32'h3);
        rd(12'hB82, 32'h0);
        retire = 1'b1;
        wr(12'hB02, 2'b01, 32'h10, 32'h3);
        rd(12'hB02, 32'h10);

        // mcycle carry into the high half
        cyc(1'b1, 12'hB00, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        rd(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB80, 32'h1);
        rd(12'hC00, 32'h1);
        wr(12'hB80, 2'b01, 32'hA, 32'h1);
        rd(12'hC80, 32'hA);

        // reset asserted while a redirect is pending
        exc_valid = 1'b1; exc_cause = 31'd1; exc_pc = 32'h900;
        idle();
        #1 rst_n = 1'b0;
        #1;
        check_bit("midtrap_redirect", redirect, 1'b0);
        check_word("midtrap_redirect_pc", redirect_pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(12'h340, 32'h0);
        rd(12'h305, MTVEC_RST);
        rd(12'h341, 32'h0);
        rd(12'h300, 32'h0000_1800);

        repeat (3) idle();
        check_word("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        check_word("redirect_queue_drained", 32'(rdr_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR register file and trap sequencer. It consumes the shared CSR access-type encoding and exception-cause codes.
- It extends the shared encodings with asynchronous interrupts (cause MSB set), configurable counter width and optional vectored trap dispatch.
- It sits beside the execute stage. It serves CSR instructions, records exceptions and interrupts, and redirects fetch on trap entry and on mret.

Parameters:
- XLEN, 32, data width of CSRs and PCs.
- COUNTER_W, 64, width of mcycle/minstret. Legal values are 32 or 64. When 32, the high-half CSRs read 0 and ignore writes.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- csr_valid  in  1  CSR instruction present this cycle
- csr_addr  in  12  CSR address
- csr_op  in  2  access type: 00 read-only, 01 write, 10 set, 11 clear
- csr_wdata  in  XLEN  operand (rs1 or zimm)
- csr_rdata  out  XLEN  old CSR value, combinational
- csr_illegal  out  1  access illegal, combinational
- exc_valid  in  1  synchronous exception raised by the pipeline
- exc_cause  in  31  exception code
- exc_pc  in  XLEN  PC of the faulting instruction
- exc_tval  in  XLEN  trap value
- mret  in  1  mret executing
- retire  in  1  one instruction retired
- irq_msi, irq_mti, irq_mei  in  1 each  level interrupt inputs
- int_pc  in  XLEN  PC to save when an interrupt is taken
- redirect  out  1  registered one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  out  XLEN  registered target
- irq_pending  out  1  an enabled interrupt is pending and would be taken

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state: mstatus.MIE=0, mstatus.MPIE=0, mie=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mtval=0, counters=0, redirect=0, redirect_pc=0.

CSR map:
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] reads 11. Other bits read 0.
- mie 0x304: bits 3/7/11 writable.
- mtvec 0x305.
- mscratch 0x340.
- mepc 0x341: bits[1:0] forced 0.
- mcause 0x342.
- mtval 0x343.
- mip 0x344: read-only view of irq inputs at bits 3/7/11; writes silently ignored.
- mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
- cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82.
- mhartid 0xF14 reads 0.

CSR access:
- csr_rdata returns the pre-write value.
- Write takes effect at the next clock edge. new = wdata, old|wdata or old&~wdata for op 01, 10, 11 respectively.
- csr_illegal=1 when csr_valid and either the address is unmapped, or addr[11:10]==11 with op!=00.
- An illegal access modifies nothing.

Counters:
- mcycle increments every cycle.
- minstret increments when retire=1.
- A CSR write to a counter half in the same cycle wins over the increment.
- Carry propagates from the low half into the high half (64-bit case).

Trap priority per cycle, highest first:
- exc_valid
- interrupt
- mret
- CSR write

Exception handling:
- On exc_valid: mepc<=exc_pc, mcause<={0,exc_cause}, mtval<=exc_tval, MPIE<=MIE, MIE<=0.
- Next cycle: redirect=1, redirect_pc = mtvec base ({mtvec[XLEN-1:2],2'b00}).
- A concurrent CSR write is dropped.

Interrupt handling:
- Pending set = MIE & mie & mip, evaluated only when exc_valid=0.
- Priority among interrupts: MEI(11) > MSI(3) > MTI(7).
- On taking one: mepc<=int_pc, mcause<={1,code}, mtval<=0, MPIE<=MIE, MIE<=0, redirect pulse as for exceptions.
- irq_pending mirrors the pending condition combinationally.

mret:
- MIE<=MPIE, MPIE<=1.
- Next cycle: redirect=1, redirect_pc=mepc.
- If an interrupt is pending in the same cycle, the interrupt wins and mret is ignored.

Other rules:
- redirect is held for exactly one cycle. A back-to-back trap produces consecutive pulses.
- Reset asserted mid-trap clears the pending redirect immediately.

Optional Feature:
- CSR_VECTORED_EN defined:
  - mtvec[1:0] is writable; only values 00 and 01 are retained, and writes of 10/11 store 00.
  - With mode 01, an interrupt targets base+4*code.
  - Exceptions always target base.
- CSR_VECTORED_EN undefined:
  - mtvec[1:0] is hardwired to 00 and all traps target base.

Test Plan:
- Reset release, read 0x300/0x305 with op 00 -> rdata 0x00001800 and MTVEC_RESET. csr_illegal=0.
- Write 0x340 with 0xDEADBEEF, then set 0x0000FFFF, then clear 0xFF000000 -> successive reads 0xDEADBEEF, 0xDEADFFFF, 0x00ADFFFF.
- exc_valid with cause 2, pc 0x100, tval 0x13, mtvec 0x200 -> next cycle redirect=1, redirect_pc=0x200. mepc=0x100, mcause=2, mtval=0x13, MIE cleared.
- MIE=1, mie=0x888, irq_mti and irq_mei both high, mtvec 0x201 (vectored build) -> mcause=0x8000000B, redirect_pc=0x22C. Non-vectored build -> redirect_pc=0x200.
- mret after the trap -> redirect_pc=mepc, MIE restored to 1, MPIE=1.
- Write 0xC00 with op 01 -> csr_illegal=1, no state change. Write mcycle 0xFFFFFFFF in a 64-bit build -> two cycles later mcycleh=1.
